// File: rtl/fetch_queue.sv
// Sequential instruction fetch with a circular prefetch queue, branch redirect and halt detection.
// Optional FETCH_BYPASS_EN: an empty queue forwards the freshly fetched word straight to decode.
module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                IMEM_AW  = 12,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OPC = 4'hF
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INST_W-1:0]  imem_rdata,
    input  logic               redir_valid,
    input  logic [ADDR_W-1:0]  redir_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INST_W-1:0]  out_inst,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               over,
    output logic               done
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] pc;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;

    logic [INST_W-1:0] inst_q [QDEPTH];
    logic [ADDR_W-1:0] pc_q   [QDEPTH];

    logic halt_word;
    logic q_pop;
    logic can_fetch;
    logic fetch;
    logic bypass;
    logic push;
    logic unused_bits;

    assign unused_bits = ^redir_addr[1:0];

    assign imem_addr = pc[IMEM_AW+1:2];
    assign halt_word = imem_rdata[INST_W-1 -: 4] == HALT_OPC;
    assign q_pop     = (count != '0) && out_ready;
    assign can_fetch = !over && ((count < CW'(QDEPTH)) || q_pop);
    assign fetch     = can_fetch && !halt_word;

`ifdef FETCH_BYPASS_EN
    assign bypass = (count == '0) && fetch && !redir_valid;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that decode takes immediately never occupies a queue slot.
    assign push = fetch && !(bypass && out_ready);

    assign out_valid = (count != '0) || bypass;
    assign out_inst  = bypass ? imem_rdata : inst_q[rd_ptr];
    assign out_pc    = bypass ? pc : pc_q[rd_ptr];
    assign done      = over && (count == '0);

    always_comb begin
        count_next = count;
        case ({push, q_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            over   <= 1'b0;
        end else if (redir_valid) begin
            pc     <= {redir_addr[ADDR_W-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            over   <= 1'b0;
        end else begin
            if (can_fetch && halt_word) begin
                over <= 1'b1;
            end
            if (fetch) begin
                pc <= pc + ADDR_W'(4);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
        end
    end

    // Storage is deliberately not reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !redir_valid) begin
            inst_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build): a vector table for the halt program
// plus hand-written sequences for stall, redirect, halt-redirect and async reset.
module tb_fetch_queue;
    logic        clk;
    logic        reset_n;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        over;
    logic        done;

    logic [31:0] mem [0:255];
    int n_chk = 0;
    int n_err = 0;

    fetch_queue dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .over        (over),
        .done        (done)
    );

    assign imem_rdata = mem[imem_addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic        eover;
        logic        edone;
    } vec_t;

    vec_t tab [6];

    function automatic logic [31:0] exp_inst(input int idx);
        case (idx)
            0:       return 32'h0000_0011;
            1:       return 32'h0000_0022;
            2:       return 32'h0000_0033;
            3:       return 32'h0000_0044;
            default: return 32'h0000_1000 + 32'(idx);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_prog(input logic with_halt);
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + 32'(i);
        mem[0] = 32'h0000_0011;
        mem[1] = 32'h0000_0022;
        mem[2] = 32'h0000_0033;
        mem[3] = with_halt ? 32'hF000_0000 : 32'h0000_0044;
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        redir_valid = 1'b0;
        redir_addr  = '0;
        out_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        redir_valid = 1'b0;
        redir_addr  = '0;
        out_ready   = 1'b0;

        // Halt program, decode always ready.
        tab[0] = '{1'b1, 1'b0, 32'h0, 32'h0,          1'b0, 1'b0};
        tab[1] = '{1'b1, 1'b1, 32'h0, 32'h0000_0011,  1'b0, 1'b0};
        tab[2] = '{1'b1, 1'b1, 32'h4, 32'h0000_0022,  1'b0, 1'b0};
        tab[3] = '{1'b1, 1'b1, 32'h8, 32'h0000_0033,  1'b0, 1'b0};
        tab[4] = '{1'b1, 1'b0, 32'h0, 32'h0,          1'b1, 1'b1};
        tab[5] = '{1'b1, 1'b0, 32'h0, 32'h0,          1'b1, 1'b1};

        load_prog(1'b1);
        do_reset();
        for (int r = 0; r < 6; r++) begin
            out_ready = tab[r].rdy;
            #1;
            $display("vec %0d: valid=%0b pc=%h inst=%h over=%0b done=%0b",
                     r, out_valid, out_pc, out_inst, over, done);
            chk("tab_valid", 32'(out_valid), 32'(tab[r].ev));
            if (tab[r].ev) begin
                chk("tab_pc",   out_pc,   tab[r].epc);
                chk("tab_inst", out_inst, tab[r].einst);
            end
            chk("tab_over", 32'(over), 32'(tab[r].eover));
            chk("tab_done", 32'(done), 32'(tab[r].edone));
            @(negedge clk);
        end

        // Stall for 10 cycles, then drain the full queue with decode ready.
        load_prog(1'b0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'b0;
            #1;
            if (i == 9) begin
                $display("stall: valid=%0b pc=%h imem_addr=%h", out_valid, out_pc, imem_addr);
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_head_pc", out_pc, 32'h0);
                chk("stall_fetch_addr", 32'(imem_addr), 32'd4);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            out_ready = 1'b1;
            #1;
            $display("drain %0d: pc=%h inst=%h imem_addr=%h", k, out_pc, out_inst, imem_addr);
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_pc", out_pc, 32'(4 * k));
            chk("drain_inst", out_inst, exp_inst(k));
            chk("drain_fetch_addr", 32'(imem_addr), 32'(k + 4));
            @(negedge clk);
        end

        // Redirect to 0x43 (low bits dropped) while three entries are queued.
        load_prog(1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
        end
        redir_valid = 1'b1;
        redir_addr  = 32'h0000_0043;
        #1;
        $display("redir issue: valid=%0b pc=%h", out_valid, out_pc);
        chk("redir_pre_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        redir_valid = 1'b0;
        out_ready   = 1'b1;
        #1;
        $display("redir +1: valid=%0b imem_addr=%h", out_valid, imem_addr);
        chk("redir_flush_valid", 32'(out_valid), 32'd0);
        chk("redir_fetch_addr", 32'(imem_addr), 32'h10);
        @(negedge clk);
        #1;
        $display("redir +2: valid=%0b pc=%h inst=%h", out_valid, out_pc, out_inst);
        chk("redir_first_valid", 32'(out_valid), 32'd1);
        chk("redir_first_pc", out_pc, 32'h40);
        chk("redir_first_inst", out_inst, exp_inst(16));
        @(negedge clk);
        #1;
        $display("redir +3: pc=%h inst=%h", out_pc, out_inst);
        chk("redir_second_pc", out_pc, 32'h44);
        chk("redir_second_inst", out_inst, exp_inst(17));
        @(negedge clk);

        // Halt, then redirect to 0x80 clears over and resumes fetching.
        load_prog(1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            @(negedge clk);
        end
        #1;
        chk("halt_over", 32'(over), 32'd1);
        chk("halt_done", 32'(done), 32'd1);
        @(negedge clk);
        redir_valid = 1'b1;
        redir_addr  = 32'h0000_0080;
        #1;
        $display("halt hold: over=%0b imem_addr=%h", over, imem_addr);
        chk("halt_sticky", 32'(over), 32'd1);
        chk("halt_pc_hold", 32'(imem_addr), 32'd3);
        @(negedge clk);
        redir_valid = 1'b0;
        #1;
        $display("halt redir +1: over=%0b imem_addr=%h valid=%0b", over, imem_addr, out_valid);
        chk("halt_redir_over", 32'(over), 32'd0);
        chk("halt_redir_addr", 32'(imem_addr), 32'd32);
        chk("halt_redir_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        $display("halt redir +2: pc=%h inst=%h done=%0b", out_pc, out_inst, done);
        chk("halt_resume_valid", 32'(out_valid), 32'd1);
        chk("halt_resume_pc", out_pc, 32'h80);
        chk("halt_resume_inst", out_inst, exp_inst(32));
        chk("halt_resume_done", 32'(done), 32'd0);
        @(negedge clk);

        // Asynchronous reset pulse between edges while over is set and entries are queued.
        load_prog(1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
        end
        #1;
        chk("areset_pre_over", 32'(over), 32'd1);
        chk("areset_pre_valid", 32'(out_valid), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        $display("async reset: valid=%0b over=%0b done=%0b", out_valid, over, done);
        chk("areset_valid", 32'(out_valid), 32'd0);
        chk("areset_over", 32'(over), 32'd0);
        chk("areset_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("areset_restart_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        #1;
        $display("after reset: valid=%0b pc=%h inst=%h", out_valid, out_pc, out_inst);
        chk("areset_first_valid", 32'(out_valid), 32'd1);
        chk("areset_first_pc", out_pc, 32'h0);
        chk("areset_first_inst", out_inst, 32'h0000_0011);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a prefetch queue. It generates sequential fetch addresses into a combinational-read instruction memory and buffers the returned words with their PCs in a circular queue. It presents them to decode through a valid/ready handshake, and handles branch redirect, queue flush and halt-opcode detection. It sits between instruction memory and the decode stage.

## Interface
Parameters:
- ADDR_W, 32: PC / redirect address width.
- INST_W, 32: instruction width.
- IMEM_AW, 12: instruction-memory word-address width.
- QDEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: PC value after reset.
- HALT_OPC, 4'hF: value of inst[INST_W-1:INST_W-4] that marks end of program.

Ports:
- clk, in, 1: clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- imem_addr, out, IMEM_AW: equals pc[IMEM_AW+1:2]; combinational from pc.
- imem_rdata, in, INST_W: word at imem_addr, same-cycle combinational read.
- redir_valid, in, 1: branch/kill redirect this cycle.
- redir_addr, in, ADDR_W: new PC; bits [1:0] are ignored and treated as 0.
- out_valid, out, 1: head entry available.
- out_ready, in, 1: decode accepts head.
- out_inst, out, INST_W: head instruction.
- out_pc, out, ADDR_W: head PC.
- over, out, 1: halt opcode fetched; fetching stopped.
- done, out, 1: over && queue empty.

## Operation
- State:
  - pc (ADDR_W)
  - rd_ptr, wr_ptr (log2 QDEPTH, wrap modulo QDEPTH)
  - count (log2 QDEPTH + 1 bits, range 0..QDEPTH)
  - over flag
- Definitions:
  - halt_word = imem_rdata[INST_W-1:INST_W-4] == HALT_OPC.
  - pop = out_valid && out_ready.
  - can_fetch = !over && (count < QDEPTH || pop).
- Priority each cycle, highest first:
  1. redir_valid: rd_ptr = wr_ptr = 0, count = 0, pc = {redir_addr[ADDR_W-1:2], 2'b00}, over = 0. Any pop or fetch in the same cycle is discarded.
  2. can_fetch && halt_word: over = 1, pc holds, nothing is enqueued.
  3. can_fetch && !halt_word: write {pc, imem_rdata} at wr_ptr, wr_ptr++, pc += 4 (mod 2^ADDR_W).
  4. pop: rd_ptr++. count changes by +1, -1 or 0 for push and pop in the same cycle.
- Full queue (count == QDEPTH) without pop: no fetch, pc holds.
- Full queue with pop: fetch and pop both happen; count stays QDEPTH.
- Empty queue: out_valid = 0. out_inst and out_pc are don't-care; the bench must not check them.
- out_valid = count != 0. out_inst and out_pc come from the entry at rd_ptr.
- over is sticky until reset or redir_valid. A halt word fetched on a wrong path is cancelled by the redirect.
- Reset values (async, on reset_n low): pc = RESET_PC, pointers = 0, count = 0, over = 0, out_valid = 0, done = 0. Queue storage is not reset.

## Timing
- Fetch to output latency: a word fetched in cycle N is visible at the output in cycle N+1.
- Redirect: asserted in cycle N → pc = target in cycle N+1 → out_valid with out_pc = target in cycle N+2.
- Halt word at pc in cycle N → over = 1 from cycle N+1. done = 1 in the first cycle where over = 1 and count = 0.
- After sustained stall, out_ready rising in cycle N pops the head in N; the new head appears in N+1.
- Throughput: one instruction per cycle when out_ready is held high.
- Reset deassertion: the first fetch happens on the first rising edge after reset_n goes high.

## Configuration
- FETCH_BYPASS_EN defined: when count == 0, can_fetch holds, the word is not a halt word and redir_valid = 0, the fetched word drives out_inst/out_pc/out_valid combinationally in the same cycle. If out_ready is also high, the word is consumed without being enqueued. Redirect → first output latency becomes 1 cycle.
- Undefined: all outputs come from queue storage only; latency as in Timing.

## Test plan
- Reset, program at words 0..3 = 0x00000011, 0x00000022, 0x00000033, 0xF0000000, out_ready = 1 → outputs (pc, inst) = (0, 0x11), (4, 0x22), (8, 0x33). over = 1 in the cycle after pc = 12; done = 1 once drained; nothing further is output.
- out_ready = 0 for 10 cycles, QDEPTH = 4 → count saturates at 4 and pc = 16. Release out_ready → outputs at pc 0, 4, 8, 12 in order with no loss or duplication.
- Queue full with out_ready = 1 sustained → one output per cycle, count stays 4, pc advances by 4 every cycle.
- redir_valid with redir_addr = 0x40 while the queue holds 3 entries → out_valid = 0 the next cycle; first output 2 cycles later has out_pc = 0x40 (1 cycle with FETCH_BYPASS_EN).
- Halt word fetched, then redir_valid to 0x80 → over returns to 0 and fetching resumes from 0x80.
- reset_n pulsed low mid-stream, asynchronously between edges → out_valid, over and done drop immediately; after release, fetching restarts at RESET_PC.
